dh_t_block_seq: RTL

Parametrised successor to the fixed 27-bit Denavit–Hartenberg transform block. It accepts one joint's pre-computed sin/cos terms plus link length a and offset d through a valid/ready handshake. It builds the 4x4 homogeneous transform in either standard DH or modified DH (Craig) convention, using NUM_MULT time-shared fixed-point multipliers. It sits between the sincos stage and the matrix-chain multiplier of the forward-kinematics pipeline.

---
 rtl/dh_t_block_seq_if.sv | 27 ++
 rtl/dh_t_block_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dh_t_block_seq_if.sv
// Handshake and data bundle between the sincos stage, the DH transform block and the chain multiplier.
interface dh_t_block_seq_if #(
  parameter int W = 27
);
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic [W-1:0]      sin_theta;
  logic [W-1:0]      cos_theta;
  logic [W-1:0]      sin_alpha;
  logic [W-1:0]      cos_alpha;
  logic [W-1:0]      a;
  logic [W-1:0]      d;
  logic              out_valid;
  logic              out_ready;
  logic [16*W-1:0]   t_matrix;

  modport master (
    output in_valid, mode, sin_theta, cos_theta, sin_alpha, cos_alpha, a, d, out_ready,
    input  in_ready, out_valid, t_matrix
  );

  modport slave (
    input  in_valid, mode, sin_theta, cos_theta, sin_alpha, cos_alpha, a, d, out_ready,
    output in_ready, out_valid, t_matrix
  );
endinterface

// File: rtl/dh_t_block_seq.sv
// Sequential DH / modified-DH 4x4 transform builder with NUM_MULT time-shared saturating multipliers.
// state | meaning:  IDLE | waiting for input   MUL | one product pass per edge   DONE | t_matrix valid, waiting for out_ready
module dh_t_block_seq #(
  parameter int W        = 27,
  parameter int FRAC     = 8,
  parameter int NUM_MULT = 1
) (
  input  logic             clk,
  input  logic             rst,
  dh_t_block_seq_if.slave  bus
);

  generate
    if (!(NUM_MULT == 1 || NUM_MULT == 2 || NUM_MULT == 3 || NUM_MULT == 6)) begin : g_bad_num_mult
      $error("dh_t_block_seq: NUM_MULT must be 1, 2, 3 or 6");
    end
  endgenerate

  localparam int P = (NUM_MULT > 0) ? 6 / NUM_MULT : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1} << FRAC;

  function automatic logic signed [W-1:0] mul_sat(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
    logic signed [2*W-1:0] full;
    logic signed [2*W-1:0] sh;
    full = (2*W)'(x) * (2*W)'(y);
    sh   = full >>> FRAC;
    if (sh > (2*W)'(MAXV))      mul_sat = MAXV;
    else if (sh < (2*W)'(MINV)) mul_sat = MINV;
    else                        mul_sat = sh[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] x);
    neg_sat = (x == MINV) ? MAXV : -x;
  endfunction

  logic [1:0]            state;
  logic [2:0]            pass;
  logic                  mode_r;
  logic signed [W-1:0]   st, ct, sa, ca, a_r, d_r;
  logic signed [W-1:0]   prod     [6];
  logic signed [W-1:0]   prod_nxt [6];
  logic signed [W-1:0]   op_x [NUM_MULT];
  logic signed [W-1:0]   op_y [NUM_MULT];
  logic signed [W-1:0]   mres [NUM_MULT];
  logic [2:0]            slot [NUM_MULT];
  logic signed [W-1:0]   e    [16];
  logic [16*W-1:0]       t_nxt;
  logic                  accept;
  logic                  last_pass;

  assign bus.in_ready  = !rst && (state == S_IDLE || (state == S_DONE && bus.out_ready));
  assign bus.out_valid = (state == S_DONE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_pass     = (state == S_MUL) && (pass == 3'(P - 1));

  // Operand routing: multiplier k serves slot pass*NUM_MULT+k this edge.
  always_comb begin
    for (int k = 0; k < NUM_MULT; k++) begin
      slot[k] = 3'(int'(pass) * NUM_MULT + k);
      op_x[k] = '0;
      op_y[k] = '0;
      case (slot[k])
        3'd0: begin op_x[k] = st; op_y[k] = ca; end
        3'd1: if (mode_r) begin op_x[k] = ct;  op_y[k] = ca; end
              else        begin op_x[k] = st;  op_y[k] = sa; end
        3'd2: if (mode_r) begin op_x[k] = sa;  op_y[k] = d_r; end
              else        begin op_x[k] = a_r; op_y[k] = ct; end
        3'd3: if (mode_r) begin op_x[k] = st;  op_y[k] = sa; end
              else        begin op_x[k] = ct;  op_y[k] = ca; end
        3'd4: begin op_x[k] = ct; op_y[k] = sa; end
        3'd5: if (mode_r) begin op_x[k] = ca;  op_y[k] = d_r; end
              else        begin op_x[k] = a_r; op_y[k] = st; end
        default: ;
      endcase
      mres[k] = mul_sat(op_x[k], op_y[k]);
    end
  end

  always_comb begin
    for (int s = 0; s < 6; s++) begin
      prod_nxt[s] = prod[s];
      for (int k = 0; k < NUM_MULT; k++)
        if (slot[k] == 3'(s)) prod_nxt[s] = mres[k];
    end
  end

  // Matrix is assembled from prod_nxt so the last pass's products land in the same edge.
  always_comb begin
    for (int i = 0; i < 16; i++) e[i] = '0;
    e[15] = ONE;
    e[0]  = ct;
    e[10] = ca;
    if (!mode_r) begin
      e[1]  = neg_sat(prod_nxt[0]);
      e[2]  = prod_nxt[1];
      e[3]  = prod_nxt[2];
      e[4]  = st;
      e[5]  = prod_nxt[3];
      e[6]  = neg_sat(prod_nxt[4]);
      e[7]  = prod_nxt[5];
      e[9]  = sa;
      e[11] = d_r;
    end else begin
      e[1]  = neg_sat(st);
      e[3]  = a_r;
      e[4]  = prod_nxt[0];
      e[5]  = prod_nxt[1];
      e[6]  = neg_sat(sa);
      e[7]  = neg_sat(prod_nxt[2]);
      e[8]  = prod_nxt[3];
      e[9]  = prod_nxt[4];
      e[11] = prod_nxt[5];
    end
    for (int i = 0; i < 16; i++) t_nxt[i*W +: W] = e[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pass         <= '0;
      mode_r       <= 1'b0;
      st           <= '0;
      ct           <= '0;
      sa           <= '0;
      ca           <= '0;
      a_r          <= '0;
      d_r          <= '0;
      bus.t_matrix <= '0;
      for (int s = 0; s < 6; s++) prod[s] <= '0;
    end else begin
      case (state)
        S_MUL: begin
          for (int s = 0; s < 6; s++) prod[s] <= prod_nxt[s];
          pass <= pass + 3'd1;
          if (last_pass) begin
            bus.t_matrix <= t_nxt;
            state        <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: ;
      endcase
      if (accept) begin
        mode_r <= bus.mode;
        st     <= bus.sin_theta;
        ct     <= bus.cos_theta;
        sa     <= bus.sin_alpha;
        ca     <= bus.cos_alpha;
        a_r    <= bus.a;
        d_r    <= bus.d;
        pass   <= '0;
        state  <= S_MUL;
      end
    end
  end

endmodule
